// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream.
// The stream carries a 16-bit little-endian word count followed by that many
// little-endian 32-bit instructions. Each completed instruction is written in
// one cycle to consecutive word-aligned byte addresses starting at 0. Words
// past the memory depth are consumed but not written, and flag overflow.
module imem_loader #(
  parameter int SIZE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] words_written
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Memory depth widened by one bit so word counts up to 65535 compare cleanly.
  localparam logic [16:0] SIZE_L = 17'(SIZE);

  state_t      state_r;
  state_t      state_next_s;

  logic [15:0] len_r;          // header word count N
  logic [15:0] index_r;        // index of the word currently being assembled
  logic [1:0]  lane_r;         // next byte lane to fill within the word
  logic [23:0] word_lo_r;      // lanes 0..2 of the word being assembled

  logic        byte_ready_r;
  logic        wr_en_r;
  logic [31:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic        busy_r;
  logic        done_r;
  logic        overflow_r;
  logic [31:0] words_written_r;

  logic [15:0] len_full_s;     // header count once the high byte arrives
  logic        in_range_s;     // current word index fits in the memory
  logic        last_word_s;    // current word is the final one of the load

  assign len_full_s  = {byte_in, len_r[7:0]};
  assign in_range_s  = ({1'b0, index_r} < SIZE_L);
  assign last_word_s = ((index_r + 16'd1) == len_r);

  // Next-state decode; only handshake states look at byte_valid.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next_s = ST_LEN_LO;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LEN_LO: begin
        if (byte_valid) begin
          state_next_s = ST_LEN_HI;
        end else begin
          state_next_s = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (byte_valid) begin
          if (len_full_s == 16'd0) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (byte_valid && (lane_r == 2'd3)) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_ready_r <= (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
                      (state_next_s == ST_DATA);
      busy_r       <= (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
                      (state_next_s == ST_DATA)   || (state_next_s == ST_WRITE);
      done_r       <= (state_next_s == ST_DONE);
    end
  end

  // Header capture, word assembly, write port and load bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r           <= 16'd0;
      index_r         <= 16'd0;
      lane_r          <= 2'd0;
      word_lo_r       <= 24'd0;
      wr_en_r         <= 1'b0;
      wr_addr_r       <= 32'd0;
      wr_data_r       <= 32'd0;
      overflow_r      <= 1'b0;
      words_written_r <= 32'd0;
    end else begin
      // The write strobe lasts exactly one cycle unless re-armed below.
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_r           <= 16'd0;
            index_r         <= 16'd0;
            lane_r          <= 2'd0;
            word_lo_r       <= 24'd0;
            overflow_r      <= 1'b0;
            words_written_r <= 32'd0;
          end else begin
            len_r <= len_r;
          end
        end
        ST_LEN_LO: begin
          if (byte_valid) begin
            len_r[7:0] <= byte_in;
          end else begin
            len_r <= len_r;
          end
        end
        ST_LEN_HI: begin
          if (byte_valid) begin
            len_r[15:8] <= byte_in;
            if ({1'b0, len_full_s} > SIZE_L) begin
              overflow_r <= 1'b1;
            end else begin
              overflow_r <= overflow_r;
            end
          end else begin
            len_r <= len_r;
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            lane_r <= lane_r + 2'd1;
            case (lane_r)
              2'd0: word_lo_r[7:0]   <= byte_in;
              2'd1: word_lo_r[15:8]  <= byte_in;
              2'd2: word_lo_r[23:16] <= byte_in;
              2'd3: begin
                // Words beyond the memory are dropped; the port keeps its last values.
                if (in_range_s) begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= {14'd0, index_r, 2'b00};
                  wr_data_r <= {byte_in, word_lo_r};
                end else begin
                  wr_en_r <= 1'b0;
                end
              end
              default: word_lo_r <= word_lo_r;
            endcase
          end else begin
            lane_r <= lane_r;
          end
        end
        ST_WRITE: begin
          index_r <= index_r + 16'd1;
          if (wr_en_r) begin
            words_written_r <= words_written_r + 32'd1;
          end else begin
            words_written_r <= words_written_r;
          end
        end
        default: begin
          index_r <= index_r;
        end
      endcase
    end
  end

  assign byte_ready    = byte_ready_r;
  assign wr_en         = wr_en_r;
  assign wr_addr       = wr_addr_r;
  assign wr_data       = wr_data_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign overflow      = overflow_r;
  assign words_written = words_written_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 128-word and a 4-word instance share one
// stimulus stream; each scenario checks the instance(s) it is about.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready, wr_en, busy, done, overflow;
  logic [31:0] wr_addr, wr_data, words_written;
  logic        byte_ready4, wr_en4, busy4, done4, overflow4;
  logic [31:0] wr_addr4, wr_data4, words_written4;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] wa4[$];
  logic [31:0] wd4[$];
  logic        rdy_cnt_en = 1'b0;
  int          nrdy = 0;

  imem_loader #(.SIZE(128)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .words_written(words_written)
  );

  imem_loader #(.SIZE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .overflow(overflow4), .words_written(words_written4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor and count of busy cycles with byte_ready low.
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (wr_en4) begin
      wa4.push_back(wr_addr4);
      wd4.push_back(wr_data4);
    end
    if (!rdy_cnt_en) nrdy = 0;
    else if (busy && !byte_ready) nrdy = nrdy + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    else return 32'hxxxx_xxxx;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns one negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    budget     = 0;
    while (!byte_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) chk("accept_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_ww", words_written, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Basic two-word load
    wa.delete(); wd.delete();
    pulse_start();
    chk("basic_busy_after_start", 32'(busy), 32'd1);
    chk("basic_ready_after_start", 32'(byte_ready), 32'd1);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h0010_0013, 0);
    chk("basic_w0_wr_en", 32'(wr_en), 32'd1);
    chk("basic_w0_ready_low", 32'(byte_ready), 32'd0);
    send_word(32'h0020_0093, 0);
    chk("basic_w1_wr_en", 32'(wr_en), 32'd1);
    chk("basic_w1_addr", wr_addr, 32'h4);
    chk("basic_w1_data", wr_data, 32'h0020_0093);
    chk("basic_done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_off", 32'(busy), 32'd0);
    chk("basic_wr_en_off", 32'(wr_en), 32'd0);
    chk("basic_nwrites", 32'(wa.size()), 32'd2);
    chk("basic_addr0", qget(wa, 0), 32'h0);
    chk("basic_data0", qget(wd, 0), 32'h0010_0013);
    chk("basic_addr1", qget(wa, 1), 32'h4);
    chk("basic_data1", qget(wd, 1), 32'h0020_0093);
    chk("basic_ww", words_written, 32'd2);
    chk("basic_ovf", 32'(overflow), 32'd0);
    chk("basic_hold_data", wr_data, 32'h0020_0093);

    // Empty program
    wa.delete(); wd.delete();
    pulse_start();
    chk("empty_done_cleared", 32'(done), 32'd0);
    chk("empty_ww_cleared", words_written, 32'd0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("empty_nwrites", 32'(wa.size()), 32'd0);
    chk("empty_ww", words_written, 32'd0);

    // Stalled one-word load
    wa.delete(); wd.delete();
    pulse_start();
    rdy_cnt_en = 1'b1;
    send_byte(8'h01, 3); send_byte(8'h00, 3);
    send_word(32'h3CC3_5AA5, 3);
    @(negedge clk);
    chk("stall_ready_low_cycles", 32'(nrdy), 32'd1);
    rdy_cnt_en = 1'b0;
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_nwrites", 32'(wa.size()), 32'd1);
    chk("stall_addr", qget(wa, 0), 32'h0);
    chk("stall_data", qget(wd, 0), 32'h3CC3_5AA5);

    // start while busy is ignored
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h78, 0);
    pulse_start();
    chk("busy_start_still_busy", 32'(busy), 32'd1);
    send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    @(negedge clk);
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_nwrites", 32'(wa.size()), 32'd1);
    chk("busy_start_data", qget(wd, 0), 32'h1234_5678);
    chk("busy_start_ww", words_written, 32'd1);

    // start in DONE begins the overflow load (SIZE=4 instance under test)
    wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
    pulse_start();
    chk("restart_done_cleared", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    send_byte(8'h06, 0); send_byte(8'h00, 0);
    @(negedge clk);
    chk("ovf_flag_early", 32'(overflow4), 32'd1);
    chk("ovf_flag_big", 32'(overflow), 32'd0);
    for (int i = 1; i <= 6; i++) send_word({8{i[3:0]}}, 0);
    @(negedge clk);
    chk("ovf_done", 32'(done4), 32'd1);
    chk("ovf_busy", 32'(busy4), 32'd0);
    chk("ovf_flag", 32'(overflow4), 32'd1);
    chk("ovf_ww", words_written4, 32'd4);
    chk("ovf_nwrites", 32'(wa4.size()), 32'd4);
    chk("ovf_addr3", qget(wa4, 3), 32'hC);
    chk("ovf_data0", qget(wd4, 0), 32'h1111_1111);
    chk("ovf_data3", qget(wd4, 3), 32'h4444_4444);
    chk("ovf_big_ww", words_written, 32'd6);
    chk("ovf_big_data5", qget(wd, 5), 32'h6666_6666);

    // Reset in the middle of word 0, then a fresh load
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(byte_ready), 32'd0);
    chk("mrst_wr_en", 32'(wr_en), 32'd0);
    chk("mrst_ovf4", 32'(overflow4), 32'd0);
    chk("mrst_data", wr_data, 32'd0);
    chk("mrst_nwrites", 32'(wa.size()), 32'd0);
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("mrst_reload_done", 32'(done), 32'd1);
    chk("mrst_reload_nwrites", 32'(wa.size()), 32'd1);
    chk("mrst_reload_addr", qget(wa, 0), 32'h0);
    chk("mrst_reload_data", qget(wd, 0), 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
